// File: rtl/fa_bist_pkg.sv
// Shared constants for the full-adder BIST controller: FSM encodings, LFSR setup, reference model.
package fa_bist_pkg;

    localparam int          LFSR_W    = 8;
    localparam logic [7:0]  LFSR_SEED = 8'hA5;
    // x^8+x^6+x^5+x^4+1 -> feedback from q[7], q[5], q[4], q[3]
    localparam logic [7:0]  LFSR_TAPS = 8'hB8;
    localparam int          EXH_CNT   = 8;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_APPLY = 2'd1;
    localparam state_t ST_CHECK = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

    // Golden full-adder response, returned as {sum, carry}.
    function automatic logic [1:0] fa_ref(input logic a, input logic b, input logic cin);
        return {a ^ b ^ cin, (a & b) | (cin & (a ^ b))};
    endfunction

endpackage

// File: rtl/fa_bist_if.sv
// Full-adder connection: the BIST drives a/b/cin and reads back s/c.
interface fa_bist_if;
    logic a;
    logic b;
    logic cin;
    logic s;
    logic c;

    modport master (output a, b, cin, input s, c);
    modport slave  (input a, b, cin, output s, c);
endinterface

// File: rtl/fa_bist_lfsr.sv
// 8-bit Fibonacci LFSR; load restores the seed, step shifts once (load wins).
module fa_bist_lfsr
    import fa_bist_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              step,
    output logic [LFSR_W-1:0] q
);

    logic [LFSR_W-1:0] r_q;
    logic              w_fb;

    assign w_fb = ^(r_q & LFSR_TAPS);
    assign q    = r_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q <= LFSR_SEED;
        end else if (load) begin
            r_q <= LFSR_SEED;
        end else if (step) begin
            r_q <= {r_q[LFSR_W-2:0], w_fb};
        end
    end

endmodule

// File: rtl/fa_bist_ctrl.sv
// BIST controller for a combinational full adder: exhaustive or LFSR sweep, two cycles per vector.
// Optional FA_BIST_FAULT_INJ_EN adds port inj, which inverts the expected sum during CHECK.
module fa_bist_ctrl
    import fa_bist_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        mode,
    input  logic [7:0]  rand_len,
`ifdef FA_BIST_FAULT_INJ_EN
    input  logic        inj,
`endif
    fa_bist_if.master   fa,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [7:0]  err_cnt,
    output logic        fail_valid,
    output logic [2:0]  fail_vec
);

    state_t            r_state;
    logic              r_mode;
    logic [7:0]        r_idx;
    logic [7:0]        r_last;
    logic [7:0]        r_err;
    logic              r_fail_vld;
    logic [2:0]        r_fail_vec;
    logic              r_a;
    logic              r_b;
    logic              r_cin;

    logic              w_start_ok;
    logic              w_inj;
    logic [1:0]        w_exp;
    logic              w_mis;
    logic [2:0]        w_vec;
    logic [LFSR_W-1:0] w_lfsr_q;
    logic [4:0]        w_lfsr_unused;

`ifdef FA_BIST_FAULT_INJ_EN
    assign w_inj = inj;
`else
    assign w_inj = 1'b0;
`endif

    assign w_start_ok    = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_exp         = fa_ref(r_a, r_b, r_cin) ^ {w_inj, 1'b0};
    assign w_mis         = (fa.s != w_exp[1]) || (fa.c != w_exp[0]);
    assign w_vec         = r_mode ? w_lfsr_q[2:0] : r_idx[2:0];
    assign w_lfsr_unused = w_lfsr_q[LFSR_W-1:3];

    fa_bist_lfsr u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (w_start_ok),
        .step  (r_state == ST_CHECK),
        .q     (w_lfsr_q)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_mode     <= 1'b0;
            r_idx      <= 8'd0;
            r_last     <= 8'd0;
            r_err      <= 8'd0;
            r_fail_vld <= 1'b0;
            r_fail_vec <= 3'd0;
            r_a        <= 1'b0;
            r_b        <= 1'b0;
            r_cin      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_start_ok) begin
                        r_state    <= ST_APPLY;
                        r_mode     <= mode;
                        // rand_len of 0 wraps to 255 and so yields 256 vectors
                        r_last     <= mode ? (rand_len - 8'd1) : 8'(EXH_CNT - 1);
                        r_idx      <= 8'd0;
                        r_err      <= 8'd0;
                        r_fail_vld <= 1'b0;
                        r_fail_vec <= 3'd0;
                    end
                end
                ST_APPLY: begin
                    {r_a, r_b, r_cin} <= w_vec;
                    r_state           <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (w_mis) begin
                        if (r_err != 8'hFF) begin
                            r_err <= r_err + 8'd1;
                        end
                        if (!r_fail_vld) begin
                            r_fail_vld <= 1'b1;
                            r_fail_vec <= {r_a, r_b, r_cin};
                        end
                    end
                    if (r_idx == r_last) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_idx   <= r_idx + 8'd1;
                        r_state <= ST_APPLY;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign fa.a       = r_a;
    assign fa.b       = r_b;
    assign fa.cin     = r_cin;
    assign busy       = (r_state == ST_APPLY) || (r_state == ST_CHECK);
    assign done       = (r_state == ST_DONE);
    assign pass       = done && (r_err == 8'd0);
    assign err_cnt    = r_err;
    assign fail_valid = r_fail_vld;
    assign fail_vec   = r_fail_vec;

endmodule

// File: tb/tb_fa_bist_ctrl.sv
// Scoreboard bench for fa_bist_ctrl with a behavioural full adder that can have its carry stuck at 0.
module tb_fa_bist_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       mode;
    logic [7:0] rand_len;
    logic       tb_inj;
    logic       tb_c_stuck;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] err_cnt;
    logic       fail_valid;
    logic [2:0] fail_vec;

    typedef struct {
        int         lat;
        logic [7:0] err;
        logic       fv;
        logic [2:0] fvec;
        logic       pass;
    } res_t;

    logic [2:0] vec_q[$];
    res_t       res_q[$];
    int         n_vec = 0;
    int         n_err = 0;

    fa_bist_if fa ();

    assign fa.s = fa.a ^ fa.b ^ fa.cin;
    assign fa.c = tb_c_stuck ? 1'b0 : ((fa.a & fa.b) | (fa.cin & (fa.a ^ fa.b)));

    fa_bist_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .mode       (mode),
        .rand_len   (rand_len),
`ifdef FA_BIST_FAULT_INJ_EN
        .inj        (tb_inj),
`endif
        .fa         (fa),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .err_cnt    (err_cnt),
        .fail_valid (fail_valid),
        .fail_vec   (fail_vec)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] lfsr_next(input logic [7:0] q);
        return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
    endfunction

    // Builds expectations, starts a run, checks every applied vector and the final status.
    task automatic run_test(input logic m, input logic [7:0] len, input logic stuck,
                            input logic inj_v, input logic mid_start);
        int         nv;
        int         n;
        int         k;
        logic [7:0] lf;
        logic [2:0] v;
        logic       s_dut, c_dut, s_exp, c_exp;
        res_t       r;
        res_t       got;

        nv     = m ? ((len == 8'd0) ? 256 : int'(len)) : 8;
        lf     = 8'hA5;
        r.err  = 8'd0;
        r.fv   = 1'b0;
        r.fvec = 3'd0;
        for (int i = 0; i < nv; i++) begin
            v = m ? lf[2:0] : 3'(i);
            lf = lfsr_next(lf);
            vec_q.push_back(v);
            s_dut = v[2] ^ v[1] ^ v[0];
            c_dut = stuck ? 1'b0 : ((v[2] & v[1]) | (v[0] & (v[2] ^ v[1])));
            s_exp = v[2] ^ v[1] ^ v[0] ^ inj_v;
            c_exp = (v[2] & v[1]) | (v[0] & (v[2] ^ v[1]));
            if ((s_dut != s_exp) || (c_dut != c_exp)) begin
                if (r.err != 8'hFF) r.err = r.err + 8'd1;
                if (!r.fv) begin
                    r.fv   = 1'b1;
                    r.fvec = v;
                end
            end
        end
        r.lat  = 2 * nv + 1;
        r.pass = (r.err == 8'd0);
        res_q.push_back(r);

        tb_c_stuck = stuck;
        tb_inj     = inj_v;
        @(negedge clk);
        start    = 1'b1;
        mode     = m;
        rand_len = len;
        @(posedge clk);
        n = 0;
        k = 0;
        while (n <= 2 * nv + 10) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                start = 1'b0;
                check_eq("start_done_low", done, 1'b0);
                check_eq("start_err_clr", err_cnt, 8'd0);
                check_eq("start_pass_low", pass, 1'b0);
                check_eq("start_busy", busy, 1'b1);
            end
            if (mid_start && n == 5) start = 1'b1;
            if (mid_start && n == 6) start = 1'b0;
            if (n == 2 * k + 2 && vec_q.size() > 0) begin
                v = vec_q.pop_front();
                check_eq($sformatf("vec%0d", k), {fa.a, fa.b, fa.cin}, v);
                k++;
            end
            if (done) break;
        end
        if (!done) check_eq("done_timeout", done, 1'b1);
        if (vec_q.size() != 0) begin
            check_eq("vecs_left", vec_q.size(), 0);
            vec_q.delete();
        end
        got = res_q.pop_front();
        check_eq("latency", n, got.lat);
        check_eq("err_cnt", err_cnt, got.err);
        check_eq("fail_valid", fail_valid, got.fv);
        check_eq("fail_vec", fail_vec, got.fvec);
        check_eq("pass", pass, got.pass);
        repeat (3) @(negedge clk);
        check_eq("hold_done", done, 1'b1);
        check_eq("hold_err", err_cnt, got.err);
        check_eq("hold_pass", pass, got.pass);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_busy"}, busy, 1'b0);
        check_eq({tag, "_done"}, done, 1'b0);
        check_eq({tag, "_pass"}, pass, 1'b0);
        check_eq({tag, "_err"}, err_cnt, 8'd0);
        check_eq({tag, "_fv"}, fail_valid, 1'b0);
        check_eq({tag, "_fvec"}, fail_vec, 3'd0);
        check_eq({tag, "_abc"}, {fa.a, fa.b, fa.cin}, 3'd0);
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        mode       = 1'b0;
        rand_len   = 8'd0;
        tb_inj     = 1'b0;
        tb_c_stuck = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("rst");

        run_test(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
        run_test(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
        run_test(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
        run_test(1'b1, 8'd10, 1'b0, 1'b0, 1'b0);
        run_test(1'b1, 8'd0, 1'b0, 1'b0, 1'b0);

        // Abort a faulty exhaustive run during its 4th CHECK (vector 011 in flight).
        tb_c_stuck = 1'b1;
        @(negedge clk);
        start = 1'b1;
        mode  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        check_eq("pre_rst_abc", {fa.a, fa.b, fa.cin}, 3'b011);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_all_zero("midrst");
        run_test(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
        run_test(1'b1, 8'd10, 1'b0, 1'b0, 1'b0);

`ifdef FA_BIST_FAULT_INJ_EN
        run_test(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
        tb_inj = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fa_bist_ctrl.md
FA_BIST_CTRL -- requirements
Module: fa_bist_ctrl

Interface
REQ-001 Clocking/reset SHALL be: one clock; reset is synchronous and active-low.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  synchronous active-low reset.
REQ-004 start  input  1  run request, sampled in IDLE or DONE.
REQ-005 mode  input  1  0 = exhaustive 8-vector sweep, 1 = LFSR pseudo-random; sampled with start.
REQ-006 rand_len  input  8  LFSR-mode vector count, sampled with start; 0 means 256.
REQ-007 a, b, cin  output  1 each  registered stimulus to the full-adder DUT; {a,b,cin} = vec[2:0], a is MSB.
REQ-008 s, c  input  1 each  DUT sum/carry, combinational response to a/b/cin.
REQ-009 busy  output  1  high in APPLY/CHECK.
REQ-010 done  output  1  high in DONE.
REQ-011 pass  output  1  valid while done; 1 iff err_cnt == 0.
REQ-012 err_cnt  output  8  mismatch count, saturates at 255.
REQ-013 fail_valid  output  1  sticky; set on first mismatch of a run.
REQ-014 fail_vec  output  3  {a,b,cin} of first mismatch; held until next run start.

Function
REQ-015 FSM states SHALL be IDLE, APPLY, CHECK, DONE.
- IDLE->APPLY on start; DONE->APPLY on start; APPLY->CHECK always; CHECK->APPLY if vectors remain, else ->DONE.
REQ-016 On run start: err_cnt, fail_valid, fail_vec cleared; vector index cleared; LFSR reloaded with seed.
REQ-017 APPLY SHALL register the current vector onto a/b/cin; a/b/cin hold through CHECK.
REQ-018 CHECK SHALL compare s against a^b^cin and c against (a&b)|(cin&(a^b)); any bit mismatch = one error.
REQ-019 Exhaustive mode: vectors 0..7 ascending; 16 cycles busy; done asserted at cycle t+17 when start is sampled at cycle t.
REQ-020 LFSR mode: 8-bit Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1, seed 8'hA5; vector = lfsr[2:0]; LFSR advances once per CHECK; N vectors take 2N cycles busy.
REQ-021 err_cnt SHALL saturate at 8'hFF; fail_vec/fail_valid capture only the first mismatch.
REQ-022 start while busy SHALL be ignored (no restart, no effect on counters).
REQ-023 DONE SHALL hold done, pass, err_cnt and fail_* until the next start or reset.
REQ-024 pass SHALL read 0 outside DONE.

Reset
REQ-025 rst_n low at any clock edge, including mid-run, SHALL force IDLE and clear a, b, cin, busy, done, pass, err_cnt, fail_valid, fail_vec and the vector index; LFSR SHALL reload the seed.
REQ-026 First start after reset release SHALL behave identically to a start from power-up.

Configuration
REQ-027 Macro FA_BIST_FAULT_INJ_EN: when defined, an extra input port inj (1 bit) SHALL exist, and while inj = 1 in CHECK the expected sum is inverted, forcing a mismatch on every vector.
REQ-028 When FA_BIST_FAULT_INJ_EN is undefined, port inj SHALL be absent and the expected values SHALL never be altered.

Structure
REQ-029 Package fa_bist_pkg SHALL hold the state enum, LFSR width (8), seed (8'hA5), tap mask and exhaustive count (8).
REQ-030 LFSR SHALL be a sub-module fa_bist_lfsr (ports: clk, rst_n, load, step, q[7:0]).
REQ-031 The block SHALL connect to the DUT via the team's existing full-adder interface signals a, b, cin, s, c.

Verification
REQ-032 Good DUT, mode=0, start at t -> a/b/cin walk 000..111; done=1 at t+17; pass=1; err_cnt=0; fail_valid=0.
REQ-033 DUT with carry stuck-at-0, mode=0 -> err_cnt=4; fail_vec=3'b011; fail_valid=1; pass=0.
REQ-034 Good DUT, mode=1, rand_len=10 -> 10 vectors matching the reference LFSR model from seed A5; done at t+21; pass=1.
REQ-035 rst_n low for one cycle during the 4th CHECK -> all outputs 0 next cycle; new start yields the full REQ-032 result.
REQ-036 start pulsed while busy -> ignored; start in DONE -> restart with err_cnt cleared and done low at the next cycle.
REQ-037 FA_BIST_FAULT_INJ_EN defined, inj=1, good DUT, mode=0 -> err_cnt=8; fail_vec=3'b000; pass=0.
